// File: rtl/fifo_word_unpacker.sv
// fifo_word_unpacker
// Reads wide words from a sync FIFO with a registered read path of RD_LATENCY
// cycles, keeps them in a small local buffer and streams each word out as
// LANES elements of ELEM_WIDTH bits over a valid/ready handshake.
//
// Build option: define UNPACK_MSB_FIRST_EN to emit the most significant lane
// of each word first. Without it, lane 0 is the least significant element.
module fifo_word_unpacker #(
    parameter int DATA_WIDTH = 64,
    parameter int ELEM_WIDTH = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic                  fifo_rd_cs,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ELEM_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy
);

    localparam int LANES     = DATA_WIDTH / ELEM_WIDTH;
    localparam int BUF_DEPTH = RD_LATENCY + 1;
    localparam int PTR_W     = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W     = $clog2(BUF_DEPTH + 1);
    localparam int LANE_W    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int SH_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CNT_W:0]    DEPTH_LIM = (CNT_W + 1)'(BUF_DEPTH);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    typedef logic [PTR_W-1:0]  ptr_t;
    typedef logic [CNT_W-1:0]  cnt_t;
    typedef logic [LANE_W-1:0] lane_t;

    // Registered state and its next-state values.
    ptr_t                  wr_ptr_q, wr_ptr_d;
    ptr_t                  rd_ptr_q, rd_ptr_d;
    cnt_t                  occ_q, occ_d;
    lane_t                 lane_idx_q, lane_idx_d;
    logic [RD_LATENCY-1:0] inflight_q, inflight_d;

    // Local word storage, indexed by the buffer pointers.
    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];

    // Decoded control.
    cnt_t                  pending;
    logic [CNT_W:0]        fill;
    logic                  capture;
    logic                  fire;
    logic                  lane_end;
    logic                  pop;
    lane_t                 lane_sel;
    logic [SH_W-1:0]       lane_base;
    logic [DATA_WIDTH-1:0] head_word;

    // Pointer advance with wrap at BUF_DEPTH (depth need not be a power of two).
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Read issue: only request a word when a buffer slot is guaranteed for it,
    // counting words already buffered plus words still travelling back.
    always_comb begin
        pending    = CNT_W'($countones(inflight_q));
        fill       = {1'b0, occ_q} + {1'b0, pending};
        fifo_rd_en = !rst && !fifo_empty && !flush && (fill < DEPTH_LIM);
        fifo_rd_cs = fifo_rd_en;
    end

    // Handshake decode: word capture from the FIFO, element accept, word pop.
    always_comb begin
        capture  = inflight_q[RD_LATENCY-1] && !flush;
        fire     = out_valid && out_ready;
        lane_end = (lane_idx_q == LAST_LANE);
        pop      = fire && lane_end && !flush;
    end

    // Next-state logic; flush overrides every other update.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path leaves a variable unassigned and no latch is inferred.
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        lane_idx_d = lane_idx_q;
        inflight_d = RD_LATENCY'({inflight_q, fifo_rd_en});

        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            occ_d      = '0;
            lane_idx_d = '0;
            inflight_d = '0;
        end else begin
            if (capture) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (fire) begin
                lane_idx_d = lane_end ? '0 : lane_idx_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({capture, pop})
                2'b10:   occ_d = occ_q + 1'b1;
                2'b01:   occ_d = occ_q - 1'b1;
                default: occ_d = occ_q;
            endcase
        end
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            lane_idx_q <= '0;
            inflight_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values, independent of block order.
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            lane_idx_q <= lane_idx_d;
            inflight_q <= inflight_d;
        end
    end

    // Word buffer write; contents only matter while occupancy covers the slot.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; occupancy gates every read of
        // it, so clearing it would only cost reset fan-out.
        if (capture) begin
            mem_q[wr_ptr_q] <= fifo_data;
        end
    end

    // Output path: select the current lane of the head word.
    always_comb begin
        head_word = mem_q[rd_ptr_q];
        out_valid = (occ_q != '0);
        out_last  = out_valid && lane_end;
        busy      = out_valid || (pending != '0);
`ifdef UNPACK_MSB_FIRST_EN
        lane_sel  = LAST_LANE - lane_idx_q;
`else
        lane_sel  = lane_idx_q;
`endif
        lane_base = SH_W'(lane_sel) * SH_W'(ELEM_WIDTH);
        out_data  = '0;
        if (out_valid) begin
            out_data = ELEM_WIDTH'(head_word >> lane_base);
        end
    end

endmodule
